// File: rtl/frame_pass_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_pass_sched
// Description : Frame-synchronous sequencer for the mem0 -> mem1 pixel pass.
//               Waits for a captured frame, streams one read/write pass over
//               it (write trails read by the 1-cycle BRAM latency), then
//               optionally starts the LeNet engine and waits for completion.
//               Optional build macro FRAME_PASS_SCHED_TIMEOUT_EN bounds the
//               LeNet wait to TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pass_sched #(
    parameter int width   = 640,
    parameter int height  = 480,
    parameter int TIMEOUT = 1048575
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        cam_frame_done,
    input  logic        lenet_signal,
    input  logic        lenet_done,
    output logic [18:0] rd_addr,
    output logic        rd_en,
    output logic [18:0] wr_addr,
    output logic        we,
    output logic        pass_active,
    output logic        lenet_start,
    output logic [7:0]  frame_cnt,
    output logic        overrun,
    output logic        timeout
);

    localparam int          c_frame     = width * height;
    localparam logic [18:0] c_last_addr = 19'(c_frame - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROC  = 2'd1,
        S_DRAIN = 2'd2,
        S_LENET = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [18:0] r_rd_addr;
    logic [18:0] w_rd_addr_nxt;
    logic        r_rd_en;
    logic        w_rd_en_nxt;
    logic [18:0] r_wr_addr;
    logic [18:0] w_wr_addr_nxt;
    logic        r_we;
    logic        w_we_nxt;
    logic        r_pass_active;
    logic        w_pass_active_nxt;
    logic        r_lenet_start;
    logic        w_lenet_start_nxt;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  w_frame_cnt_nxt;
    logic        r_overrun;
    logic        w_overrun_nxt;

`ifdef FRAME_PASS_SCHED_TIMEOUT_EN
    // Last value of the wait counter before the LeNet wait is abandoned:
    // the counter reads 0 in the first LENET cycle, so TIMEOUT cycles have
    // been spent when it reads TIMEOUT-1.
    localparam logic [19:0] c_wait_last = 20'(TIMEOUT - 1);

    logic [19:0] r_wait;
    logic        r_timeout;
    logic        w_wait_hit;
    logic        w_timeout_nxt;

    assign w_wait_hit = (r_state == S_LENET) && (r_wait == c_wait_last);

    // Wait counter: zero outside LENET, so it is cleared on every LENET entry.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 20'd0;
        end else if (r_state == S_LENET) begin
            r_wait <= r_wait + 20'd1;
        end else begin
            r_wait <= 20'd0;
        end
    end

    // Registered timeout pulse.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rd_addr     <= 19'd0;
            r_rd_en       <= 1'b0;
            r_wr_addr     <= 19'd0;
            r_we          <= 1'b0;
            r_pass_active <= 1'b0;
            r_lenet_start <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_addr     <= w_rd_addr_nxt;
            r_rd_en       <= w_rd_en_nxt;
            r_wr_addr     <= w_wr_addr_nxt;
            r_we          <= w_we_nxt;
            r_pass_active <= w_pass_active_nxt;
            r_lenet_start <= w_lenet_start_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt       = r_state;
        w_rd_addr_nxt     = r_rd_addr;
        w_rd_en_nxt       = 1'b0;
        w_wr_addr_nxt     = r_wr_addr;
        w_we_nxt          = 1'b0;
        w_pass_active_nxt = 1'b0;
        w_lenet_start_nxt = 1'b0;
        w_frame_cnt_nxt   = r_frame_cnt;
        // A frame arriving while busy is dropped and flagged.
        w_overrun_nxt     = cam_frame_done && (r_state != S_IDLE);
`ifdef FRAME_PASS_SCHED_TIMEOUT_EN
        w_timeout_nxt     = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (cam_frame_done) begin
                    w_state_nxt       = S_PROC;
                    w_rd_en_nxt       = 1'b1;
                    w_rd_addr_nxt     = 19'd0;
                    w_pass_active_nxt = 1'b1;
                end
            end

            S_PROC: begin
                // Write the pixel whose read was issued this cycle; it
                // returns from the BRAM one cycle later.
                w_pass_active_nxt = 1'b1;
                w_we_nxt          = 1'b1;
                w_wr_addr_nxt     = r_rd_addr;
                if (r_rd_addr == c_last_addr) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_rd_en_nxt   = 1'b1;
                    w_rd_addr_nxt = r_rd_addr + 19'd1;
                end
            end

            S_DRAIN: begin
                w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                if (lenet_signal) begin
                    w_state_nxt       = S_LENET;
                    w_lenet_start_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_LENET: begin
                // r_lenet_start is high only in the first LENET cycle, in
                // which a done pulse cannot belong to this run.
                if (!r_lenet_start && lenet_done) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef FRAME_PASS_SCHED_TIMEOUT_EN
                else if (w_wait_hit) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end
`endif
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_addr     = r_rd_addr;
    assign rd_en       = r_rd_en;
    assign wr_addr     = r_wr_addr;
    assign we          = r_we;
    assign pass_active = r_pass_active;
    assign lenet_start = r_lenet_start;
    assign frame_cnt   = r_frame_cnt;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: doc/frame_pass_sched.md
Name: frame_pass_sched

Overview:
- Per-frame sequencer for the pixel-processing datapath between the camera frame buffer (mem0) and the VGA frame buffer (mem1).
- Waits for a captured frame and streams exactly one read/write pass over it, with write address lagging read address by the 1-cycle BRAM read latency.
- Optionally hands the finished frame to the LeNet engine and waits for it to complete.
- Replaces free-running address counters with a frame-synchronous, handshake-driven pass.

Parameters:
- width, 640, pixels per line
- height, 480, lines per frame; derived localparam c_frame = width*height (must be ≤ 2^19)
- TIMEOUT, 1048575, max cycles to wait for lenet_done (used only with the optional feature)

Ports:
- clk25  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- cam_frame_done  input  1  1-cycle pulse: camera finished writing a frame into mem0
- lenet_signal  input  1  level: run LeNet after each pass
- lenet_done  input  1  1-cycle pulse from LeNet engine
- rd_addr  output  19  mem0 read address
- rd_en  output  1  mem0 read enable
- wr_addr  output  19  mem1 write address
- we  output  1  mem1 write enable
- pass_active  output  1  high in PROC and DRAIN
- lenet_start  output  1  1-cycle start pulse to LeNet
- frame_cnt  output  8  completed passes, wraps 255→0
- overrun  output  1  1-cycle pulse: frame dropped
- timeout  output  1  1-cycle pulse: LeNet wait aborted

Behaviour:
- Interface: one clock, clk25; reset rst_n is asynchronous, active-low.
- Reset (asserted at any time, including mid-pass): state = IDLE. All outputs 0: rd_addr, wr_addr, frame_cnt, rd_en, we, pass_active, lenet_start, overrun, timeout. All outputs are registered.
- States: IDLE, PROC, DRAIN, LENET.
- IDLE: cam_frame_done=1 in cycle T → PROC from T+1.
- PROC, pass cycle k = 0..c_frame-1:
  - rd_en=1, rd_addr=k.
  - From k≥1: we=1, wr_addr=k-1.
  - In cycle k=0, we=0.
  - After k = c_frame-1 → DRAIN.
- DRAIN (1 cycle): rd_en=0, we=1, wr_addr=c_frame-1.
  - On exit, frame_cnt increments.
  - Next state is LENET if lenet_signal=1 (sampled in DRAIN), else IDLE.
- LENET:
  - lenet_start=1 in the first LENET cycle only.
  - lenet_done is ignored in that first cycle; from the second cycle, lenet_done=1 → IDLE.
- Pass throughput: exactly c_frame writes per pass, no gaps; pass length = c_frame+1 cycles.
- Address outputs: rd_addr and wr_addr hold their last value when the corresponding enable is 0. rd_addr never reaches c_frame.
- Overrun: cam_frame_done outside IDLE (PROC, DRAIN, LENET, including the LENET→IDLE transition cycle) → overrun pulses 1 cycle later. The frame is dropped; the current pass is not restarted.
- lenet_signal is ignored outside DRAIN; changing it mid-pass has no effect on the current pass.

Optional Feature:
- Macro: FRAME_PASS_SCHED_TIMEOUT_EN.
- Defined: a 20-bit wait counter clears on LENET entry and counts LENET cycles. If it reaches TIMEOUT without lenet_done → IDLE, with timeout pulsed for 1 cycle. lenet_done in the same cycle as the limit wins: no timeout pulse.
- Undefined: LENET waits indefinitely; timeout is tied 0; no counter logic.

Test Plan (width=8, height=4, c_frame=32):
1. Reset, cam_frame_done at cycle 10, lenet_signal=0 → rd_addr 0..31 with rd_en=1 in cycles 11..42; we=1 with wr_addr 0..31 in cycles 12..43; frame_cnt=1 at cycle 44; back in IDLE.
2. lenet_signal=1, one frame → lenet_start=1 exactly at cycle 44; lenet_done at cycle 50 → IDLE at 51; lenet_done at cycle 44 is ignored.
3. cam_frame_done at cycles 10 and 20 → one pass only; overrun=1 at cycle 21; frame_cnt=1.
4. rst_n low at cycle 25 mid-pass → all outputs 0 immediately; next cam_frame_done restarts with rd_addr=0.
5. 256 back-to-back frames → frame_cnt wraps to 0; each pass performs exactly 32 writes.
6. FRAME_PASS_SCHED_TIMEOUT_EN defined, TIMEOUT=5, lenet_signal=1, no lenet_done → timeout pulses once; returns to IDLE; next frame is accepted.
